// File: rtl/out_fifo_wr_feeder.sv
// -----------------------------------------------------------------------------
// out_fifo_wr_feeder
// Write-side feeder placed directly in front of a PHY OUT_FIFO running in
// ARRAY_MODE_8_X_4. 80-bit words (ten byte lanes) arrive on a valid/ready
// stream and pass through a 2-entry skid FIFO. The feeder then writes them into
// the OUT_FIFO one word per cycle, and only while both FULL and ALMOSTFULL are
// low. After reset it performs no accepts or writes for RST_WAIT_CYCLES+1
// edges.
//
// Ports
//   WRCLK      : clock, shared with OUT_FIFO WRCLK
//   RESET      : asynchronous reset, active-high
//   S_DATA     : input word, lane k = S_DATA[8k+7:8k]
//   S_VALID    : S_DATA valid
//   S_READY    : feeder can take a word this cycle (registers only)
//   FULL       : OUT_FIFO FULL flag
//   ALMOSTFULL : OUT_FIFO ALMOSTFULL flag
//   D0..D9     : registered lane data to OUT_FIFO
//   WREN       : registered write strobe to OUT_FIFO
//   WR_COUNT   : WREN pulses issued since reset, wraps silently
//   BUSY       : skid buffer holds data or a write is on the bus
// -----------------------------------------------------------------------------
module out_fifo_wr_feeder #(
  parameter int unsigned RST_WAIT_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 WRCLK,
  input  logic                 RESET,
  input  logic [79:0]          S_DATA,
  input  logic                 S_VALID,
  output logic                 S_READY,
  input  logic                 FULL,
  input  logic                 ALMOSTFULL,
  output logic [7:0]           D0,
  output logic [7:0]           D1,
  output logic [7:0]           D2,
  output logic [7:0]           D3,
  output logic [7:0]           D4,
  output logic [7:0]           D5,
  output logic [7:0]           D6,
  output logic [7:0]           D7,
  output logic [7:0]           D8,
  output logic [7:0]           D9,
  output logic                 WREN,
  output logic [CNT_WIDTH-1:0] WR_COUNT,
  output logic                 BUSY
);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0]           WAIT_INIT = 8'(RST_WAIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [79:0]           mem_q [2];
  logic [79:0]           mem_d [2];
  logic                  head_q, head_d;
  logic [1:0]            occ_q, occ_d;
  logic                  wren_q, wren_d;
  logic [79:0]           data_q, data_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;

  logic                  ready_s;
  logic                  accept_s;
  logic                  wr_ok_s;
  logic                  pop_s;
  logic                  tail_s;

  // Handshake and issue decisions depend only on registers and the current flags.
  always_comb begin
    ready_s  = (state_q == ST_RUN) && (occ_q != 2'd2);
    accept_s = S_VALID && ready_s;
    // ALMOSTFULL also stops writes, because the OUT_FIFO flags lag the writes.
    wr_ok_s  = !FULL && !ALMOSTFULL;
    pop_s    = (state_q == ST_RUN) && (occ_q != 2'd0) && wr_ok_s;
    // The tail is the head slot when the buffer is empty, otherwise the other slot.
    tail_s   = head_q ^ occ_q[0];
  end

  // Next state: recovery countdown, skid buffer update, OUT_FIFO write issue.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_d      = mem_q;
    head_d     = head_q;
    occ_d      = occ_q;
    wren_d     = 1'b0;
    data_d     = data_q;
    wr_count_d = wr_count_q;

    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase

    // The buffer is never bypassed: an accepted word always lands in the tail first.
    if (accept_s) begin
      mem_d[tail_s] = S_DATA;
    end else begin
      mem_d[tail_s] = mem_q[tail_s];
    end

    if (pop_s) begin
      wren_d     = 1'b1;
      data_d     = mem_q[head_q];
      head_d     = ~head_q;
      wr_count_d = wr_count_q + CNT_ONE;
    end else begin
      wren_d     = 1'b0;
      data_d     = data_q;
    end

    case ({accept_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State and output registers. Reset drops any buffered words.
  always_ff @(posedge WRCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_WAIT;
      wait_cnt_q <= WAIT_INIT;
      mem_q[0]   <= 80'd0;
      mem_q[1]   <= 80'd0;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      wren_q     <= 1'b0;
      data_q     <= 80'd0;
      wr_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_q      <= mem_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign S_READY  = ready_s;
  assign WREN     = wren_q;
  assign WR_COUNT = wr_count_q;
  assign BUSY     = (occ_q != 2'd0) || wren_q;
  assign D0       = data_q[7:0];
  assign D1       = data_q[15:8];
  assign D2       = data_q[23:16];
  assign D3       = data_q[31:24];
  assign D4       = data_q[39:32];
  assign D5       = data_q[47:40];
  assign D6       = data_q[55:48];
  assign D7       = data_q[63:56];
  assign D8       = data_q[71:64];
  assign D9       = data_q[79:72];

endmodule

// File: tb/tb_out_fifo_wr_feeder.sv
// -----------------------------------------------------------------------------
// tb_out_fifo_wr_feeder
// Bench for out_fifo_wr_feeder, built with CNT_WIDTH=4 so that WR_COUNT wraps
// within a short run. Each word accepted by the DUT is pushed to a scoreboard
// queue. Every WREN pulse pops the queue and compares the word on D0..D9.
// The bench also compares WR_COUNT, BUSY and the held D value on every cycle.
// Inputs change at posedge+1. Outputs are sampled at the negedge or at
// posedge+1.
// -----------------------------------------------------------------------------
module tb_out_fifo_wr_feeder;

  localparam int CW = 4;

  logic          WRCLK = 1'b0;
  logic          RESET;
  logic [79:0]   S_DATA;
  logic          S_VALID;
  logic          S_READY;
  logic          FULL;
  logic          ALMOSTFULL;
  logic [7:0]    D0, D1, D2, D3, D4, D5, D6, D7, D8, D9;
  logic          WREN;
  logic [CW-1:0] WR_COUNT;
  logic          BUSY;
  logic [79:0]   d_all;

  int            checks = 0;
  int            errors = 0;
  logic [79:0]   sb_q [$];
  logic [79:0]   last_d;
  logic [CW-1:0] exp_cnt;
  int            wren_run;
  int            wren_run_max;

  out_fifo_wr_feeder #(.RST_WAIT_CYCLES(4), .CNT_WIDTH(CW)) dut (
    .WRCLK(WRCLK), .RESET(RESET), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_READY(S_READY), .FULL(FULL), .ALMOSTFULL(ALMOSTFULL),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7),
    .D8(D8), .D9(D9), .WREN(WREN), .WR_COUNT(WR_COUNT), .BUSY(BUSY)
  );

  assign d_all = {D9, D8, D7, D6, D5, D4, D3, D2, D1, D0};

  always #5 WRCLK = ~WRCLK;

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk_word(input logic [7:0] lane0);
    return {8'($urandom()), $urandom(), $urandom(), lane0};
  endfunction

  task automatic tick();
    @(posedge WRCLK);
    #1;
  endtask

  // Assert reset at posedge+1, check that the outputs clear without a clock edge, hold, then release.
  task automatic do_reset(input int n);
    S_VALID = 1'b0;
    RESET   = 1'b1;
    #1;
    check_val("rst_async_wren", WREN, 1'b0);
    check_val("rst_async_d", d_all, 80'd0);
    check_val("rst_async_cnt", WR_COUNT, 4'd0);
    check_val("rst_async_busy", BUSY, 1'b0);
    repeat (n) tick();
    RESET = 1'b0;
  endtask

  task automatic send(input int n, input logic [7:0] base, input bit chk_rdy);
    bit acc;
    int guard;
    for (int k = 0; k < n; k++) begin
      S_DATA  = mk_word(base + 8'(k));
      S_VALID = 1'b1;
      guard   = 0;
      if (chk_rdy) check_val("b2b_ready", S_READY, 1'b1);
      do begin
        acc = S_READY;
        tick();
        guard++;
      end while (!acc && guard < 100);
      if (!acc) check_val("send_timeout", 1'b0, 1'b1);
    end
    S_VALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (!BUSY) break;
      tick();
    end
    check_val("drain_timeout", BUSY, 1'b0);
  endtask

  // Stream ten words. After the third write, raise one OUT_FIFO flag for three edges.
  task automatic throttle(input bit use_full, input logic [7:0] base);
    int nw = 0;
    int writes = 0;
    bit stalled = 1'b0;
    bit acc;
    S_DATA  = mk_word(base);
    S_VALID = 1'b1;
    for (int c = 0; c < 200 && nw < 10; c++) begin
      acc = S_READY;
      tick();
      if (WREN) writes++;
      if (acc) begin
        nw++;
        S_DATA = mk_word(base + 8'(nw));
      end
      if (writes == 3 && !stalled) begin
        stalled = 1'b1;
        if (use_full) FULL = 1'b1;
        else ALMOSTFULL = 1'b1;
        for (int s = 0; s < 3; s++) begin
          acc = S_READY;
          tick();
          if (acc) begin
            nw++;
            S_DATA = mk_word(base + 8'(nw));
          end
          if (s == 0) check_val("thr_wren_next", WREN, 1'b0);
        end
        check_val("thr_wren", WREN, 1'b0);
        check_val("thr_ready", S_READY, 1'b0);
        check_val("thr_busy", BUSY, 1'b1);
        FULL       = 1'b0;
        ALMOSTFULL = 1'b0;
      end
    end
    check_val("thr_words", 80'(nw), 80'd10);
    S_VALID = 1'b0;
    drain();
  endtask

  // Scoreboard monitor: compare outputs at the negedge, then record the word accepted at the next edge.
  initial begin
    logic [79:0] exp_w;
    last_d       = 80'd0;
    exp_cnt      = '0;
    wren_run     = 0;
    wren_run_max = 0;
    forever begin
      @(negedge WRCLK);
      if (RESET) begin
        check_val("rst_wren", WREN, 1'b0);
        check_val("rst_d", d_all, 80'd0);
        check_val("rst_cnt", WR_COUNT, 4'd0);
        check_val("rst_busy", BUSY, 1'b0);
        check_val("rst_ready", S_READY, 1'b0);
        sb_q.delete();
        exp_cnt  = '0;
        last_d   = 80'd0;
        wren_run = 0;
      end else begin
        if (WREN) begin
          if (sb_q.size() == 0) begin
            check_val("wren_unexpected", 1'b1, 1'b0);
          end else begin
            exp_w = sb_q.pop_front();
            check_val("d_word", d_all, exp_w);
            last_d = exp_w;
          end
          exp_cnt = exp_cnt + 4'd1;
          wren_run++;
          if (wren_run > wren_run_max) wren_run_max = wren_run;
        end else begin
          check_val("d_hold", d_all, last_d);
          wren_run = 0;
        end
        check_val("wr_count", WR_COUNT, exp_cnt);
        check_val("busy", BUSY, WREN || (sb_q.size() != 0));
        if (S_VALID && S_READY) sb_q.push_back(S_DATA);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    RESET      = 1'b0;
    S_VALID    = 1'b0;
    S_DATA     = 80'd0;
    FULL       = 1'b0;
    ALMOSTFULL = 1'b0;
    #1;

    // Reset recovery and a single word.
    do_reset(3);
    S_DATA  = 80'h09_08_07_06_05_04_03_02_01_00;
    S_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("rdy_wait", S_READY, 1'b0);
    end
    tick();
    check_val("rdy_run", S_READY, 1'b1);
    tick();
    S_VALID = 1'b0;
    check_val("lat_wren0", WREN, 1'b0);
    tick();
    check_val("lat_wren1", WREN, 1'b1);
    check_val("single_d0", D0, 8'h00);
    check_val("single_d9", D9, 8'h09);
    check_val("single_cnt", WR_COUNT, 4'd1);
    tick();
    check_val("single_wren_off", WREN, 1'b0);
    check_val("single_d_hold", d_all, 80'h09_08_07_06_05_04_03_02_01_00);

    // Back-to-back burst of eight words.
    do_reset(2);
    repeat (5) tick();
    wren_run_max = 0;
    send(8, 8'h00, 1'b1);
    drain();
    check_val("b2b_run", 80'(wren_run_max), 80'd8);
    check_val("b2b_cnt", WR_COUNT, 4'd8);

    // Throttling by ALMOSTFULL, then by FULL.
    throttle(1'b0, 8'h10);
    check_val("thr_af_cnt", WR_COUNT, 4'd2);
    throttle(1'b1, 8'h20);
    check_val("thr_full_cnt", WR_COUNT, 4'd12);

    // Reset while a stream is being written.
    S_DATA  = mk_word(8'h31);
    S_VALID = 1'b1;
    guard   = 0;
    while (!WREN && guard < 50) begin
      if (S_READY) S_DATA = mk_word(8'h31 + 8'(guard));
      tick();
      guard++;
    end
    check_val("mid_pre_wren", WREN, 1'b1);
    do_reset(2);
    send(1, 8'hA5, 1'b0);
    tick();
    check_val("mid_first_wren", WREN, 1'b1);
    check_val("mid_first_d0", D0, 8'hA5);
    check_val("mid_first_cnt", WR_COUNT, 4'd1);
    drain();

    // WR_COUNT wrap after 17 writes.
    do_reset(2);
    send(17, 8'h40, 1'b0);
    drain();
    check_val("wrap_cnt", WR_COUNT, 4'd1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_fifo_wr_feeder.md
Name: out_fifo_wr_feeder

Overview:
Write-side feeder stage directly upstream of the PHY OUT_FIFO in ARRAY_MODE_8_X_4. It accepts 80-bit words (10 byte lanes) on a valid/ready stream and buffers them in a 2-entry skid FIFO. It drives the FIFO's D0..D9/WREN inputs one word per cycle, throttled by the FIFO's FULL/ALMOSTFULL flags. After reset it holds off writes for a programmable recovery window.

Parameters:
RST_WAIT_CYCLES, 4, cycles after RESET deassertion before any write is accepted or issued (0..255)
CNT_WIDTH, 16, width of the issued-write counter WR_COUNT

Ports:
WRCLK  in  1  single clock, shared with OUT_FIFO WRCLK
RESET  in  1  asynchronous reset, active-high
S_DATA  in  80  input word; lane k = S_DATA[8k+7:8k]
S_VALID  in  1  S_DATA valid
S_READY  out  1  feeder can accept a word this cycle
FULL  in  1  OUT_FIFO FULL flag
ALMOSTFULL  in  1  OUT_FIFO ALMOSTFULL flag
D0..D9  out  8 each  lane data to OUT_FIFO D0..D9
WREN  out  1  write strobe to OUT_FIFO
WR_COUNT  out  CNT_WIDTH  number of WREN pulses issued since reset, wraps
BUSY  out  1  skid buffer non-empty or WREN high

Behaviour:
- Reset is asynchronous, active-high, and is decided: one clock (WRCLK), reset RESET. While RESET=1: WREN=0, D0..D9=0, S_READY=0, WR_COUNT=0, BUSY=0, skid occupancy=0, state=WAIT, wait counter=RST_WAIT_CYCLES.
- State WAIT: wait counter decrements each WRCLK edge. It moves to RUN on the edge where the counter is 0. With RST_WAIT_CYCLES=0, RUN is entered on the first edge after RESET falls. S_READY=0 and WREN=0 throughout WAIT.
- State RUN: remains in RUN until RESET. There are no other transitions.
- S_READY is combinational from registers: (state==RUN) && (occ<2). accept = S_VALID && S_READY. S_DATA is not sampled when accept=0.
- wr_ok = !FULL && !ALMOSTFULL, sampled at the WRCLK edge. Writing stops at ALMOSTFULL so that the flag latency of OUT_FIFO cannot overrun it.
- Issue at each edge in RUN:
  - If occ>0 and wr_ok: WREN<=1, D0..D9<=head entry, pop head, WR_COUNT<=WR_COUNT+1 (mod 2^CNT_WIDTH).
  - Otherwise: WREN<=0 and D0..D9 hold their previous value.
- Skid buffer: 2-entry FIFO with strict order. It is not bypassed, so accepted data always spends at least one cycle in the buffer.
- Simultaneous accept and pop: occ is unchanged, the new word goes to the tail, and order is preserved.
- occ==2: S_READY=0. A pop on an edge makes S_READY=1 in the following cycle (no combinational path from FULL/ALMOSTFULL to S_READY).
- Latency: word accepted at edge N into an empty buffer with wr_ok=1 appears on D with WREN=1 after edge N+1 (2 edges). Sustained throughput is 1 word/cycle while wr_ok=1.
- wr_ok falls: WREN is 0 after the next edge. The buffered words (≤2) are retained and issued in order once wr_ok returns.
- BUSY = (occ!=0) || WREN.
- Reset mid-operation: everything clears immediately and buffered words are discarded without being written. After RESET falls the block re-enters WAIT for the full RST_WAIT_CYCLES.
- WR_COUNT wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Test Plan:
1. Reset recovery: RESET high 3 cycles then low, S_VALID=1, FULL=ALMOSTFULL=0 -> S_READY stays 0 for exactly 4 edges after RESET falls; first WREN=1 occurs 2 edges after first accept.
2. Single word: S_DATA=80'h09_08_07_06_05_04_03_02_01_00 accepted at edge N -> after edge N+1: WREN=1, D0=8'h00 … D9=8'h09, WR_COUNT=1; after edge N+2: WREN=0, D holds.
3. Back-to-back: 8 consecutive words (lane0 = 0..7), flags low -> WREN high for 8 consecutive cycles, D0 sequence 0..7, S_READY never drops, WR_COUNT=8.
4. Throttle: ALMOSTFULL forced high mid-burst after 3 writes, S_VALID held -> WREN=0 from next edge, 2 words buffered, S_READY=0. Releasing ALMOSTFULL gives in-order issue of words 3,4,5… with no loss or duplication.
5. Reset mid-burst: RESET pulsed while occ=2 and WREN=1 -> WREN, D, WR_COUNT, BUSY go to 0 asynchronously. After release, no stale word is ever written and the first write carries the first post-reset word.
6. Counter wrap: CNT_WIDTH=4, issue 17 writes -> WR_COUNT reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
